// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation tables, per-round shift counts,
// widths, and the 28-bit half-register rotation helper.
package des_pkg;

    localparam int KEY_W      = 64;
    localparam int CD_W       = 28;
    localparam int SUBKEY_W   = 48;
    localparam int NUM_ROUNDS = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } ks_state_t;

    // PC-1: entry i names the key bit (1 = MSB) that lands in C/D position i+1.
    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: entry i names the {C,D} bit (1 = MSB) that lands in subkey position i+1.
    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT [1:16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Left moves bits toward position 1 (the MSB); amt is 1 or 2.
    function automatic logic [1:CD_W] rotate_cd(input logic [1:CD_W] v,
                                                 input logic          left,
                                                 input logic [1:0]    amt);
        logic [1:CD_W] r;
        if (left) begin
            r = (amt == 2'd2) ? {v[3:CD_W], v[1:2]} : {v[2:CD_W], v[1]};
        end else begin
            r = (amt == 2'd2) ? {v[CD_W-1:CD_W], v[1:CD_W-2]} : {v[CD_W], v[1:CD_W-1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Permuted Choice 2: selects the 48 round-key bits from the 56-bit {C,D} pair.
module des_pc2
    import des_pkg::*;
(
    input  logic [1:2*CD_W]   cd,
    output logic [1:SUBKEY_W] subkey
);

    for (genvar g = 0; g < SUBKEY_W; g++) begin : g_pc2
        assign subkey[g+1] = cd[PC2[g]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator: loads a key, then hands out K1..K16
// (or K16..K1 for decrypt) one per valid/ready transfer.
module des_key_schedule
    import des_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              decrypt,
    input  logic [1:KEY_W]    key_in,
    output logic              busy,
    output logic              k_valid,
    input  logic              k_ready,
    output logic [1:SUBKEY_W] subkey,
    output logic [3:0]        round_idx,
    output logic              done,
    output ks_state_t         state
);

    // Handshake: a subkey moves when k_valid and k_ready are both high on a
    // rising edge; while k_valid is high and k_ready low, subkey and round_idx
    // hold, and k_valid never drops until its subkey has been taken.

    ks_state_t     state_q, state_d;
    logic          mode_q;
    logic [3:0]    round_q;
    logic [1:CD_W] c_q, d_q;
    logic          done_q;

    logic [1:2*CD_W] c0d0;
    logic [1:CD_W]   c0, d0;
    logic            accept, xfer, last;
    logic [4:0]      sh_idx;
    logic [1:0]      sh_amt;

    for (genvar g = 0; g < 2*CD_W; g++) begin : g_pc1
        assign c0d0[g+1] = key_in[PC1[g]];
    end

    assign c0 = c0d0[1:CD_W];
    assign d0 = c0d0[CD_W+1:2*CD_W];

    assign accept = (state_q == ST_IDLE) && start;
    assign xfer   = k_valid && k_ready;
    assign last   = (round_q == 4'(NUM_ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)        state_d = ST_GEN;
            ST_GEN:  if (xfer && last) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Encrypt walks forward through SHIFT; decrypt undoes the shifts in reverse,
    // starting from C0/D0 because the 16 left shifts sum to a full rotation.
    always_comb begin
        sh_idx = mode_q ? (5'd16 - {1'b0, round_q}) : ({1'b0, round_q} + 5'd2);
        if (sh_idx > 5'd16) begin
            sh_idx = 5'd16;
        end
        sh_amt = SHIFT[sh_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= 1'b0;
            round_q <= 4'd0;
            c_q     <= '0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= xfer && last;
            if (accept) begin
                mode_q  <= decrypt;
                round_q <= 4'd0;
                if (decrypt) begin
                    c_q <= c0;
                    d_q <= d0;
                end else begin
                    c_q <= rotate_cd(c0, 1'b1, SHIFT[1]);
                    d_q <= rotate_cd(d0, 1'b1, SHIFT[1]);
                end
            end else if (xfer && !last) begin
                round_q <= round_q + 4'd1;
                c_q     <= rotate_cd(c_q, !mode_q, sh_amt);
                d_q     <= rotate_cd(d_q, !mode_q, sh_amt);
            end
        end
    end

    des_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (subkey)
    );

    assign busy      = (state_q == ST_GEN);
    assign k_valid   = (state_q == ST_GEN);
    assign round_idx = round_q;
    assign done      = done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed and randomized checks of des_key_schedule against a bit-level
// reference model of the DES key schedule built from cumulative rotations.
module tb_des_key_schedule;

  localparam logic [63:0] K_KAT = 64'h133457799BBCDFF1;
  localparam logic [63:0] K_PAR = 64'h123556789ABDDEF0;
  localparam logic [47:0] K1_KAT = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_KAT = 48'hCB3D8B0E17F5;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, start, decrypt, k_ready;
  logic [63:0] key_in;
  logic busy, k_valid, done;
  logic [47:0] subkey;
  logic [3:0] round_idx;
  des_pkg::ks_state_t state;

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .decrypt   (decrypt),
    .key_in    (key_in),
    .busy      (busy),
    .k_valid   (k_valid),
    .k_ready   (k_ready),
    .subkey    (subkey),
    .round_idx (round_idx),
    .done      (done),
    .state     (state)
  );

  // ---------------- scoreboard ----------------
  logic [47:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Subkey for round rnd (1..16): C_rnd/D_rnd are C0/D0 rotated left by the
  // total shift count so far, then PC-2 picks the 48 output bits.
  function automatic logic [47:0] model_subkey(input logic [63:0] key, input int rnd);
    bit cd0 [1:56];
    bit cdr [1:56];
    int cum;
    logic [47:0] r;
    for (int j = 1; j <= 56; j++) cd0[j] = key[64 - PC1_T[j-1]];
    cum = 0;
    for (int i = 0; i < rnd; i++) cum += SHIFT_T[i];
    for (int j = 1; j <= 28; j++) begin
      cdr[j]      = cd0[((j - 1 + cum) % 28) + 1];
      cdr[j + 28] = cd0[28 + ((j - 1 + cum) % 28) + 1];
    end
    for (int k = 1; k <= 48; k++) r[48 - k] = cdr[PC2_T[k-1]];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // rdy_mode: 0 = always ready, 1 = random ~50%, 2 = every other cycle.
  // interfere_at / reset_at: transfer count at which to poke start / rst (-1 = never).
  task automatic run_job(input logic [63:0] dut_key, input logic [63:0] model_key,
                         input logic dec, input int rdy_mode,
                         input int interfere_at, input int reset_at,
                         output logic [47:0] first_k, output logic [47:0] last_k);
    int n;
    int cyc;
    logic rdy;
    logic [47:0] cur_k;
    logic [3:0] cur_i;
    logic [47:0] exp;
    first_k = '0;
    last_k = '0;
    exp_q.delete();
    for (int r = 1; r <= 16; r++) exp_q.push_back(model_subkey(model_key, dec ? 17 - r : r));
    key_in = dut_key;
    decrypt = dec;
    start = 1'b1;
    k_ready = 1'b0;
    tick();
    start = 1'b0;
    key_in = rand64();
    decrypt = ~dec;
    check("accept_busy", busy, 1);
    check("accept_valid", k_valid, 1);
    n = 0;
    cyc = 0;
    while (n < 16 && cyc < 400) begin
      cyc++;
      case (rdy_mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: rdy = cyc[0];
      endcase
      k_ready = rdy;
      if (reset_at == n) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        k_ready = 1'b0;
        check("rst_valid", k_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_subkey", subkey, 0);
        check("rst_round", round_idx, 0);
        check("rst_done", done, 0);
        exp_q.delete();
        return;
      end
      if (interfere_at == n) begin
        start = 1'b1;
        key_in = rand64();
        decrypt = ~dec;
      end
      cur_k = subkey;
      cur_i = round_idx;
      check("valid_in_gen", k_valid, 1);
      if (rdy) begin
        exp = exp_q.pop_front();
        check("subkey", cur_k, exp);
        check("round_idx", cur_i, n);
        if (n == 0) first_k = cur_k;
        if (n == 15) last_k = cur_k;
        n++;
      end
      tick();
      start = 1'b0;
      if (!rdy) begin
        check("stall_subkey", subkey, cur_k);
        check("stall_round", round_idx, cur_i);
      end else if (n == 16) begin
        check("done_pulse", done, 1);
        check("idle_after_last", busy, 0);
      end else begin
        check("done_early", done, 0);
      end
    end
    if (n < 16) check("timeout_transfers", n, 16);
    k_ready = 1'b0;
  endtask

  task automatic idle_check();
    tick();
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  logic [47:0] f_k, l_k;
  logic [63:0] rk;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    decrypt = 1'b0;
    k_ready = 1'b0;
    key_in = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_valid", k_valid, 0);
    check("reset_done", done, 0);
    check("reset_subkey", subkey, 0);
    check("reset_round", round_idx, 0);

    check("model_k1", model_subkey(K_KAT, 1), K1_KAT);
    check("model_k16", model_subkey(K_KAT, 16), K16_KAT);

    // Encrypt, ready held high.
    run_job(K_KAT, K_KAT, 1'b0, 0, -1, -1, f_k, l_k);
    check("enc_first", f_k, K1_KAT);
    check("enc_last", l_k, K16_KAT);
    idle_check();

    // Decrypt, ready held high.
    run_job(K_KAT, K_KAT, 1'b1, 0, -1, -1, f_k, l_k);
    check("dec_first", f_k, K16_KAT);
    check("dec_last", l_k, K1_KAT);
    idle_check();

    // Random and alternating stalls.
    run_job(K_KAT, K_KAT, 1'b0, 1, -1, -1, f_k, l_k);
    check("stall_first", f_k, K1_KAT);
    idle_check();
    run_job(K_KAT, K_KAT, 1'b0, 2, -1, -1, f_k, l_k);
    check("alt_last", l_k, K16_KAT);
    idle_check();

    // Start with a different key while busy at round 5.
    run_job(K_KAT, K_KAT, 1'b0, 1, 5, -1, f_k, l_k);
    idle_check();

    // Reset at round 7, then a clean restart.
    run_job(K_KAT, K_KAT, 1'b0, 0, -1, 7, f_k, l_k);
    run_job(K_KAT, K_KAT, 1'b0, 0, -1, -1, f_k, l_k);
    check("restart_first", f_k, K1_KAT);
    idle_check();

    // Parity bits flipped must not matter.
    run_job(K_PAR, K_KAT, 1'b0, 0, -1, -1, f_k, l_k);
    idle_check();

    // Back-to-back: second start lands in the done cycle.
    rk = rand64();
    run_job(rk, rk, 1'b0, 0, -1, -1, f_k, l_k);
    rk = rand64();
    run_job(rk, rk, 1'b1, 1, -1, -1, f_k, l_k);
    idle_check();

    // Start coincident with reset is discarded.
    rst = 1'b1;
    start = 1'b1;
    key_in = K_KAT;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst_start_busy", busy, 0);
    check("rst_start_valid", k_valid, 0);
    tick();
    check("rst_start_still_idle", busy, 0);

    // Random keys, modes and stalls.
    for (int t = 0; t < 6; t++) begin
      rk = rand64();
      run_job(rk, rk, 1'($urandom_range(0, 1)), 1, -1, -1, f_k, l_k);
      idle_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 Parameters SHALL be: none; all widths fixed by FIPS 46-3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  load request; key accepted when start=1 and busy=0.
REQ-005 decrypt  input  1  sampled with start; 1 = emit K16..K1, 0 = emit K1..K16.
REQ-006 key_in  input  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,...,64 ignored.
REQ-007 busy  output  1  high from the cycle after acceptance until the last subkey is consumed.
REQ-008 k_valid  output  1  subkey/round_idx valid.
REQ-009 k_ready  input  1  consumer (round stage) accepts subkey.
REQ-010 subkey  output  [1:48]  current round key, bit 1 = MSB, in the same form as the round stage's 48-bit key input.
REQ-011 round_idx  output  [3:0]  round number minus 1 (0 = round 1) of the current subkey.
REQ-012 done  output  1  one-cycle pulse on the cycle after the 16th transfer.

Function
REQ-013 FSM states SHALL be IDLE and GEN; busy = k_valid = (state==GEN).
REQ-014 IDLE with start=1 SHALL move to GEN next cycle; round_idx <= 0; decrypt latched into mode register.
- C0/D0 = PC-1(key_in) halves [1:28]/[29:56].
REQ-015 Encrypt load SHALL set C,D <= rotl(C0,D0, SHIFT[1]); decrypt load SHALL set C,D <= C0,D0.
REQ-016 subkey SHALL equal PC-2({C,D}), combinational from registered C,D; no added latency.
REQ-017 Transfer = k_valid & k_ready.
- No transfer: C, D, round_idx, subkey stay stable.
REQ-018 On a transfer with round_idx = r < 15, round_idx SHALL become r+1.
- Encrypt: C,D rotate left by SHIFT[r+2].
- Decrypt: C,D rotate right by SHIFT[16-r].
REQ-019 SHIFT[1..16] SHALL be 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-020 A transfer with round_idx=15 SHALL return the FSM to IDLE and assert done for exactly the next cycle.
REQ-021 start while busy=1 SHALL be ignored; key_in and decrypt changes during GEN SHALL have no effect.
REQ-022 start asserted in the cycle done is high (state IDLE) SHALL be accepted: back-to-back loads with one idle cycle.
REQ-023 k_ready held high SHALL yield 16 consecutive transfers; first subkey valid one cycle after acceptance.
REQ-024 Arbitrary k_ready stalls (including every other cycle) SHALL not skip or repeat any round.

Reset
REQ-025 rst=1 at any cycle, including mid-GEN, SHALL force on the next edge:
- state=IDLE, busy=0, k_valid=0, done=0.
- round_idx=0, C=D=0, mode=0 (so subkey=0).
REQ-026 A start coincident with rst SHALL be discarded.

Structure
REQ-027 Shared package des_pkg SHALL hold PC1 and PC2 index tables, the SHIFT table, and width constants (KEY_W=64, CD_W=28, SUBKEY_W=48, NUM_ROUNDS=16).
REQ-028 PC-2 SHALL be a combinational sub-module des_pc2 (56-in, 48-out), reusable by any unrolled key path.
REQ-029 Rotation SHALL be a package function (28-bit, direction and amount 1|2); no other sub-modules.

Verification
REQ-030 Encrypt, k_ready=1:
- Stimulus: key 0x133457799BBCDFF1.
- Response: round_idx 0 subkey 0x1B02EFFC7072; round_idx 15 subkey 0xCB3D8B0E17F5; done one cycle after the 16th transfer.
REQ-031 Decrypt, same key:
- Response: round_idx 0 subkey 0xCB3D8B0E17F5; round_idx 15 subkey 0x1B02EFFC7072.
- All 16 subkeys equal the encrypt sequence reversed.
REQ-032 Random k_ready stalls (~50%), encrypt:
- Response: sequence identical to REQ-030; subkey/round_idx stable on every stalled cycle.
REQ-033 start pulsed with a different key while busy (round_idx=5):
- Response: ignored; original sequence completes unchanged.
REQ-034 rst asserted at round_idx=7:
- Response: next cycle k_valid=0, busy=0, subkey=0.
- A following start with the REQ-030 key restarts cleanly from 0x1B02EFFC7072.
REQ-035 Parity-bit independence:
- Stimulus: REQ-030 key with all parity bits flipped (0x123556789ABDDEF0).
- Response: identical 16 subkeys.
